// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit subtract/compare unit among NREQ requesters.
// Optional signed compare enabled by defining CMP_ARBITER_SIGNED_EN (adds the sgn port).
module cmp_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a,
    input  logic [NREQ*WIDTH-1:0] b,
`ifdef CMP_ARBITER_SIGNED_EN
    input  logic [NREQ-1:0]       sgn,
`endif
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  done,
    output logic                  lt,
    output logic [WIDTH-1:0]      diff
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t           r_state;
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    r_win;
    logic [NREQ-1:0]  r_gnt;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic             r_done;
    logic             r_lt;
    logic [WIDTH-1:0] r_diff;

    logic [WIDTH-1:0] w_a_arr [NREQ];
    logic [WIDTH-1:0] w_b_arr [NREQ];
    logic             w_found;
    logic [PW-1:0]    w_win;
    logic [WIDTH:0]   w_sum;
    logic             w_lt_uns;
    logic             w_lt;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_a_arr[gi] = a[gi*WIDTH +: WIDTH];
        assign w_b_arr[gi] = b[gi*WIDTH +: WIDTH];
    end

    // First active request at or above the pointer, wrapping modulo NREQ.
    always_comb begin
        int            idx;
        logic [PW-1:0] idx_pw;
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(r_ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            idx_pw = PW'(idx);
            if (!w_found && req[idx_pw]) begin
                w_found = 1'b1;
                w_win   = idx_pw;
            end
        end
    end

    // The one shared carry chain: A + ~B + 1.
    assign w_sum    = {1'b0, r_opa} + {1'b0, ~r_opb} + (WIDTH+1)'(1);
    assign w_lt_uns = ~w_sum[WIDTH];

`ifdef CMP_ARBITER_SIGNED_EN
    logic r_sgn;
    logic w_ovf;
    assign w_ovf = (r_opa[WIDTH-1] ^ r_opb[WIDTH-1]) & (w_sum[WIDTH-1] ^ r_opa[WIDTH-1]);
    assign w_lt  = r_sgn ? (w_sum[WIDTH-1] ^ w_ovf) : w_lt_uns;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sgn <= 1'b0;
        end else if (r_state == S_IDLE && w_found) begin
            r_sgn <= sgn[w_win];
        end
    end
`else
    assign w_lt = w_lt_uns;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_gnt   <= '0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_done  <= 1'b0;
            r_lt    <= 1'b0;
            r_diff  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << w_win;
                        r_win   <= w_win;
                        r_opa   <= w_a_arr[w_win];
                        r_opb   <= w_b_arr[w_win];
                        r_state <= S_EXEC;
                    end else begin
                        r_gnt <= '0;
                    end
                end
                S_EXEC: begin
                    r_lt    <= w_lt;
                    r_diff  <= w_sum[WIDTH-1:0];
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    // gnt stays on alongside the done pulse; the next IDLE edge replaces it.
                    r_done  <= 1'b1;
                    r_ptr   <= (r_win == PW'(NREQ-1)) ? '0 : r_win + PW'(1);
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt  = r_gnt;
    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign lt   = r_lt;
    assign diff = r_diff;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Scoreboard bench for cmp_arbiter: stimulus pushes expected results, a negedge monitor checks each done.
module tb_cmp_arbiter;

    localparam int W = 8;
    localparam int N = 4;

    logic           CLK = 1'b0;
    logic           RESET = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   sgn = '0;
    logic [N*W-1:0] a = '0;
    logic [N*W-1:0] b = '0;
    logic [N-1:0]   gnt;
    logic           busy;
    logic           done;
    logic           lt;
    logic [W-1:0]   diff;

    cmp_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .req   (req),
        .a     (a),
        .b     (b),
`ifdef CMP_ARBITER_SIGNED_EN
        .sgn   (sgn),
`endif
        .gnt   (gnt),
        .busy  (busy),
        .done  (done),
        .lt    (lt),
        .diff  (diff)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int           idx;
        logic         lt;
        logic [W-1:0] diff;
    } exp_t;

    exp_t exp_q[$];
    int   err_cnt = 0;
    int   chk_cnt = 0;
    int   cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        chk_cnt++;
        if (act !== expv) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push(input int idx, input logic l, input logic [W-1:0] d);
        exp_t e;
        e.idx  = idx;
        e.lt   = l;
        e.diff = d;
        exp_q.push_back(e);
    endtask

    task automatic set_op(input int i, input logic [W-1:0] av, input logic [W-1:0] bv);
        a[i*W +: W] = av;
        b[i*W +: W] = bv;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_done(input int maxc);
        bit seen = 1'b0;
        for (int k = 0; k < maxc && !seen; k++) begin
            tick();
            if (done) seen = 1'b1;
        end
        check("done_timeout", 32'(seen), 32'd1);
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (!RESET && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(gnt), 32'd0);
                if (gnt == '0) begin
                    err_cnt++;
                    $display("FAIL unexpected_done: got done=1, expected no done (cycle %0d)", cyc);
                end
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("txn_gnt", 32'(gnt), 32'd1 << e.idx);
                check("txn_lt", 32'(lt), 32'(e.lt));
                check("txn_diff", 32'(diff), 32'(e.diff));
                $display("txn: req=%0d gnt=%b lt=%0b diff=%02h (exp lt=%0b diff=%02h)",
                         e.idx, gnt, lt, diff, e.lt, e.diff);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n_done;
        int last;
        int cnt;

        // Reset with all requests high; boundary operands on each requester.
        set_op(0, 8'h00, 8'hFF);
        set_op(1, 8'hFF, 8'h00);
        set_op(2, 8'h80, 8'h80);
        set_op(3, 8'h03, 8'h05);
        RESET = 1'b1;
        req   = 4'b1111;
        tick();
        tick();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_lt", 32'(lt), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);

        // Constant full request: order 0,1,2,3,0 with one done every 3 cycles.
        push(0, 1'b1, 8'h01);
        push(1, 1'b0, 8'hFF);
        push(2, 1'b0, 8'h00);
        push(3, 1'b1, 8'hFE);
        push(0, 1'b1, 8'h01);
        RESET  = 1'b0;
        n_done = 0;
        last   = 0;
        for (int k = 0; k < 40 && n_done < 5; k++) begin
            tick();
            if (k == 0) check("first_gnt", 32'(gnt), 32'd1);
            if (gnt == 4'b0001 && n_done == 4) req = '0;
            if (done) begin
                if (n_done > 0) check("done_spacing", 32'(cyc - last), 32'd3);
                last = cyc;
                n_done++;
            end
        end
        check("burst_dones", 32'(n_done), 32'd5);

        // Requester 1 alone: 3 - 5.
        set_op(1, 8'd3, 8'd5);
        push(1, 1'b1, 8'hFE);
        req = 4'b0010;
        tick();
        check("solo_gnt", 32'(gnt), 32'b0010);
        check("solo_busy", 32'(busy), 32'd1);
        req = '0;
        tick();
        check("solo_no_early_done", 32'(done), 32'd0);
        tick();
        check("solo_done", 32'(done), 32'd1);
        check("solo_gnt_held", 32'(gnt), 32'b0010);
        tick();
        check("solo_gnt_clear", 32'(gnt), 32'd0);
        check("solo_done_pulse", 32'(done), 32'd0);

        // Requester 2: operand change and req drop during EXEC must not affect the op.
        set_op(2, 8'd10, 8'd20);
        push(2, 1'b1, 8'hF6);
        push(0, 1'b1, 8'h01);
        req = 4'b0100;
        tick();
        check("r2_gnt", 32'(gnt), 32'b0100);
        set_op(2, 8'd30, 8'd20);
        req = 4'b0001;
        tick();
        tick();
        check("r2_done", 32'(done), 32'd1);
        tick();
        check("r2_skip", 32'(gnt), 32'b0001);
        req = '0;
        wait_done(5);

        // Reset during EXEC abandons the op and rewinds the pointer.
        req = 4'b0010;
        tick();
        check("rst_exec_gnt", 32'(gnt), 32'b0010);
        RESET = 1'b1;
        req   = '0;
        tick();
        RESET = 1'b0;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done) cnt++;
        end
        check("rst_exec_no_done", 32'(cnt), 32'd0);
        check("rst_exec_busy", 32'(busy), 32'd0);
        check("rst_exec_gnt0", 32'(gnt), 32'd0);
        check("rst_exec_lt", 32'(lt), 32'd0);
        check("rst_exec_diff", 32'(diff), 32'd0);
        push(0, 1'b1, 8'h01);
        req = 4'b0011;
        tick();
        check("ptr_after_reset", 32'(gnt), 32'b0001);
        req = '0;
        wait_done(5);

`ifdef CMP_ARBITER_SIGNED_EN
        // -1 < 1 signed; 255 > 1 unsigned.
        set_op(0, 8'hFF, 8'h01);
        sgn = 4'b0001;
        push(0, 1'b1, 8'hFE);
        req = 4'b0001;
        tick();
        req = '0;
        wait_done(5);
        sgn = 4'b0000;
        push(0, 1'b0, 8'hFE);
        req = 4'b0001;
        tick();
        req = '0;
        wait_done(5);
`endif

        tick();
        tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
